flash_writer: RTL and testbench

Write-side companion to the flash array reader, driving the same parallel NOR flash pins (Intel StrataFlash command set, x16 mode). It executes one word-program or one block-erase per request: clear status, command/data bus writes, status-register polling, then a return to read-array mode so the reader can resume. It sits between the CPU-side memory controller and the board flash pins, and shares the pins with the reader through an external owner mux.

---
 rtl/flash_writer.sv | 177 +++++++++++++++++
 tb/tb_flash_writer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_writer.sv
// flash_writer: write-side sequencer for a parallel NOR flash (StrataFlash
// command set, x16 mode). Each accepted request runs one word-program or one
// block-erase: clear status, command/argument bus writes, status polling,
// then a read-array command so the reader can resume.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req, op           start request (sampled while busy=0); 0=program 1=erase
//   addr, wdata       target word address and program data, latched on accept
//   busy, done        operation in progress / one-cycle completion pulse
//   err, timeout      valid with done: device error or poll timeout
//   status            last sampled flash status register
//   flash_addr        flash address bus
//   flash_data        flash data bus, driven only during bus writes
//   flash_ce/we/oe    active-low strobes
//   flash_rp/byte/vpen tied high
module flash_writer #(
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned MAX_POLLS = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        op,
  input  logic [22:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout,
  output logic [7:0]  status,
  output logic [22:0] flash_addr,
  inout  wire  [15:0] flash_data,
  output logic        flash_ce,
  output logic        flash_we,
  output logic        flash_oe,
  output logic        flash_rp,
  output logic        flash_byte,
  output logic        flash_vpen
);

  localparam int unsigned CNT_MAX = (WE_CYCLES + 1 > RD_CYCLES) ? WE_CYCLES + 1 : RD_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = (MAX_POLLS > 1) ? $clog2(MAX_POLLS + 1) : 1;

  localparam logic [CW-1:0] WE_LAST   = CW'(WE_CYCLES);
  localparam logic [CW-1:0] WR_HOLD   = CW'(WE_CYCLES + 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] RD_REC    = CW'(RD_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

  typedef enum logic [2:0] {IDLE, CLR, CMD, ARG, POLL, FIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;
  logic          tflag;
  logic          op_q;
  logic [15:0]   wdata_q;
  logic          drive;
  logic [15:0]   dout;
  logic          unused_hi;

  assign flash_data = drive ? dout : 16'hzzzz;
  assign flash_rp   = 1'b1;
  assign flash_byte = 1'b1;
  assign flash_vpen = 1'b1;
  assign unused_hi  = ^flash_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      poll_cnt   <= '0;
      tflag      <= 1'b0;
      op_q       <= 1'b0;
      wdata_q    <= '0;
      drive      <= 1'b0;
      dout       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      status     <= '0;
      flash_addr <= '0;
      flash_ce   <= 1'b1;
      flash_we   <= 1'b1;
      flash_oe   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          timeout <= 1'b0;
          if (req) begin
            state      <= CLR;
            cnt        <= '0;
            poll_cnt   <= '0;
            tflag      <= 1'b0;
            op_q       <= op;
            wdata_q    <= wdata;
            flash_addr <= addr;
            busy       <= 1'b1;
            flash_ce   <= 1'b0;
            flash_we   <= 1'b1;
            flash_oe   <= 1'b1;
            drive      <= 1'b1;
            dout       <= 16'h0050;
          end else begin
            state <= IDLE;
          end
        end

        // Bus write: cnt 0 = setup, 1..WE_CYCLES = we low, WE_CYCLES+1 = hold.
        // The hold cycle hands straight over to the next bus cycle so ce stays low.
        CLR, CMD, ARG, FIN: begin
          if (cnt == WR_HOLD) begin
            cnt <= '0;
            case (state)
              CLR: begin
                state <= CMD;
                dout  <= op_q ? 16'h0020 : 16'h0040;
              end
              CMD: begin
                state <= ARG;
                dout  <= op_q ? 16'h00D0 : wdata_q;
              end
              ARG: begin
                state    <= POLL;
                drive    <= 1'b0;
                flash_oe <= 1'b0;
              end
              default: begin
                state    <= DONE;
                drive    <= 1'b0;
                flash_ce <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                timeout  <= tflag;
                err      <= status[5] | status[4] | status[3] | status[1] | tflag;
              end
            endcase
          end else begin
            cnt      <= cnt + 1'b1;
            flash_we <= (cnt == WE_LAST);
          end
        end

        // Bus read: cnt 0..RD_CYCLES-1 = oe low, RD_CYCLES = recovery.
        POLL: begin
          if (cnt == RD_REC) begin
            cnt <= '0;
            if (status[7] || poll_cnt == POLL_LAST) begin
              tflag <= ~status[7];
              state <= FIN;
              drive <= 1'b1;
              dout  <= 16'h00FF;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              flash_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == RD_LAST) begin
              status   <= flash_data[7:0];
              flash_oe <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_writer.sv
// Testbench for flash_writer: a flash device model answers status reads from a
// per-operation response list, and an expected pin trace is built for each
// operation from the bus-cycle rules (write = setup + WE low + hold, read =
// OE low + recovery). One compare process checks every cycle against it.
module tb_flash_writer;
  localparam int unsigned WE_C = 2;
  localparam int unsigned RD_C = 2;
  localparam int unsigned MAXP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        op = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, err, timeout;
  logic [7:0]  status;
  logic [22:0] flash_addr;
  wire  [15:0] flash_data;
  logic        flash_ce, flash_we, flash_oe, flash_rp, flash_byte, flash_vpen;

  flash_writer #(.WE_CYCLES(WE_C), .RD_CYCLES(RD_C), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .timeout(timeout), .status(status),
    .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_ce(flash_ce), .flash_we(flash_we), .flash_oe(flash_oe),
    .flash_rp(flash_rp), .flash_byte(flash_byte), .flash_vpen(flash_vpen)
  );

  always #5 clk = ~clk;

  // Flash device: status responses indexed by read number within the operation
  logic [7:0]  resp [16];
  int unsigned rd_cnt = 0;
  int unsigned rd_base = 0;
  int unsigned rd_idx;
  logic [7:0]  dev_st;

  always_comb begin
    rd_idx = rd_cnt - rd_base;
    dev_st = resp[(rd_idx > 15) ? 4'd15 : rd_idx[3:0]];
  end
  assign flash_data = (!flash_ce && !flash_oe) ? {8'hA5, dev_st} : 16'hzzzz;
  always @(posedge flash_oe) rd_cnt <= rd_cnt + 1;

  typedef struct {
    logic        ce, we, oe, drv, busy, done, err, tmo;
    logic [15:0] data;
    logic [22:0] a;
    logic [7:0]  st;
  } ent_t;

  ent_t        exp_q[$];
  logic [7:0]  exp_status = '0;
  bit          chk_idle_addr = 1'b1;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic ent_t base_ent(input logic [22:0] a);
    ent_t e;
    e.ce = 1'b0; e.we = 1'b1; e.oe = 1'b1; e.drv = 1'b0;
    e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.tmo = 1'b0;
    e.data = '0; e.a = a; e.st = '0;
    return e;
  endfunction

  task automatic push_w(input logic [22:0] a, input logic [15:0] w);
    ent_t e;
    e = base_ent(a);
    e.drv = 1'b1; e.data = w;
    exp_q.push_back(e);
    e.we = 1'b0;
    repeat (WE_C) exp_q.push_back(e);
    e.we = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [22:0] a);
    ent_t e;
    e = base_ent(a);
    e.oe = 1'b0;
    repeat (RD_C) exp_q.push_back(e);
    e.oe = 1'b1;
    exp_q.push_back(e);
  endtask

  // Expected trace for one operation given the current response list
  task automatic push_op(input logic o, input logic [22:0] a, input logic [15:0] d);
    int         nr;
    bit         tmo;
    logic [7:0] st;
    ent_t       e;
    nr = 0; tmo = 1'b0; st = '0;
    for (int i = 0; i < 16; i++) begin
      nr++;
      st = resp[i];
      if (st[7]) break;
      if (nr == int'(MAXP)) begin tmo = 1'b1; break; end
    end
    push_w(a, 16'h0050);
    push_w(a, o ? 16'h0020 : 16'h0040);
    push_w(a, o ? 16'h00D0 : d);
    repeat (nr) push_r(a);
    push_w(a, 16'h00FF);
    e = base_ent(a);
    e.ce = 1'b1; e.busy = 1'b0; e.done = 1'b1;
    e.tmo = tmo; e.err = ((st & 8'h3A) != 8'h00) || tmo; e.st = st;
    exp_q.push_back(e);
    exp_status    = st;
    rd_base       = rd_cnt;
    chk_idle_addr = 1'b0;
  endtask

  task automatic set_resp(input int nw, input logic [7:0] fin, input bit rndw);
    for (int i = 0; i < 16; i++)
      resp[i] = (i < nw) ? (rndw ? 8'($urandom_range(0, 127)) : 8'h00) : fin;
  endtask

  task automatic start(input logic o, input logic [22:0] a, input logic [15:0] d);
    op = o; addr = a; wdata = d; req = 1'b1;
    push_op(o, a, d);
  endtask

  task automatic wait_done(input bit pulse, input bit hold, output int k,
                           output logic [7:0] st, output logic er, output logic tm);
    k = 0; st = '0; er = 1'b0; tm = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) req = 1'b0;
        addr = 23'($urandom); wdata = 16'($urandom); op = 1'($urandom);
      end
      if (pulse && c == 6) req = 1'b1;
      if (pulse && c == 7) req = 1'b0;
      if (done) begin
        k = c; st = status; er = err; tm = timeout;
        if (hold) push_op(op, addr, wdata);
        break;
      end
    end
    if (k == 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_wait: no done within 400 cycles");
      exp_q.delete(); exp_status = '0; chk_idle_addr = 1'b1;
      req = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Per-cycle compare against the expected trace, or idle values when none
  always begin
    ent_t e;
    bit   ok;
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ok = (flash_ce == e.ce) && (flash_we == e.we) && (flash_oe == e.oe) &&
           (busy == e.busy) && (done == e.done) && (flash_addr == e.a);
      if (e.drv) ok = ok && (flash_data == e.data);
      if (e.done) ok = ok && (err == e.err) && (timeout == e.tmo) && (status == e.st);
      else        ok = ok && !err && !timeout;
      if (!ok) begin
        n_bad++;
        $display("FAIL cycle t=%0t: ce=%b/%b we=%b/%b oe=%b/%b busy=%b/%b done=%b/%b addr=%h/%h data=%h/%h(drv=%b) err=%b/%b tmo=%b/%b st=%h/%h (got/expected)",
                 $time, flash_ce, e.ce, flash_we, e.we, flash_oe, e.oe, busy, e.busy,
                 done, e.done, flash_addr, e.a, flash_data, e.data, e.drv,
                 err, e.err, timeout, e.tmo, status, e.st);
      end
    end else begin
      ok = flash_ce && flash_we && flash_oe && !busy && !done && !err && !timeout &&
           (status == exp_status) && flash_rp && flash_byte && flash_vpen;
      if (chk_idle_addr) ok = ok && (flash_addr == 23'h0);
      if (!ok) begin
        n_bad++;
        $display("FAIL idle t=%0t: ce=%b we=%b oe=%b busy=%b done=%b err=%b tmo=%b st=%h/%h addr=%h rp/byte/vpen=%b%b%b",
                 $time, flash_ce, flash_we, flash_oe, busy, done, err, timeout,
                 status, exp_status, flash_addr, flash_rp, flash_byte, flash_vpen);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int         k;
    logic [7:0] st;
    logic       er, tm;

    set_resp(0, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Program, ready on first poll
    set_resp(0, 8'h80, 1'b0);
    start(1'b0, 23'h000123, 16'hBEEF);
    wait_done(1'b0, 1'b0, k, st, er, tm);
    chk("prog_latency", k, 20);
    chk("prog_err", int'(er), 0);
    chk("prog_status", int'(st), 8'h80);
    @(negedge clk);

    // Erase, three busy polls before ready
    set_resp(3, 8'h80, 1'b0);
    start(1'b1, 23'h2A5000, 16'h1234);
    wait_done(1'b0, 1'b0, k, st, er, tm);
    chk("erase_latency", k, 29);
    chk("erase_err", int'(er), 0);
    @(negedge clk);

    // Program error reported by the device
    set_resp(0, 8'h90, 1'b0);
    start(1'b0, 23'h7FFFFF, 16'h0000);
    wait_done(1'b0, 1'b0, k, st, er, tm);
    chk("perr_err", int'(er), 1);
    chk("perr_timeout", int'(tm), 0);
    chk("perr_status", int'(st), 8'h90);
    @(negedge clk);

    // Timeout: device never ready within MAX_POLLS reads
    set_resp(8, 8'h00, 1'b0);
    start(1'b1, 23'h000400, 16'h0000);
    wait_done(1'b0, 1'b0, k, st, er, tm);
    chk("tmo_latency", k, 29);
    chk("tmo_err", int'(er), 1);
    chk("tmo_timeout", int'(tm), 1);
    @(negedge clk);

    // req pulsed mid-operation and inputs scrambled: ignored
    set_resp(1, 8'h80, 1'b0);
    start(1'b0, 23'h001000, 16'hA5A5);
    wait_done(1'b1, 1'b0, k, st, er, tm);
    chk("pulse_latency", k, 23);
    repeat (3) @(negedge clk);

    // Reset during polling abandons the operation
    set_resp(8, 8'h00, 1'b0);
    start(1'b0, 23'h0ABCDE, 16'h5555);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
    end
    rst = 1'b1;
    exp_q.delete();
    exp_status = '0;
    chk_idle_addr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ce", int'(flash_ce), 1);
    set_resp(0, 8'h80, 1'b0);
    start(1'b0, 23'h0ABCDE, 16'h5555);
    wait_done(1'b0, 1'b0, k, st, er, tm);
    chk("post_rst_latency", k, 20);
    @(negedge clk);

    // req held high through DONE: back-to-back operations
    set_resp(0, 8'h80, 1'b0);
    start(1'b0, 23'h012345, 16'h0F0F);
    wait_done(1'b0, 1'b1, k, st, er, tm);
    chk("b2b_first_latency", k, 20);
    wait_done(1'b0, 1'b0, k, st, er, tm);
    chk("b2b_second_latency", k, 20);
    @(negedge clk);

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      set_resp($urandom_range(0, 5), 8'h80 | 8'($urandom_range(0, 127)), 1'b1);
      start(1'($urandom), 23'($urandom), 16'($urandom));
      wait_done(1'($urandom), 1'b0, k, st, er, tm);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
